// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins by default; a streak counter lets a waiting fetch in after MAX_D_STREAK
// data grants. A watchdog aborts grants the memory never answers and sets a sticky error.
module mem_port_arbiter #(
  parameter int unsigned W            = 32,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic         clk,
  input  logic         reset,
  // Fetch port
  input  logic         if_req,
  input  logic [W-1:0] if_addr,
  output logic [W-1:0] if_rdata,
  output logic         if_ack,
  // Data port
  input  logic         d_req,
  input  logic         d_we,
  input  logic [W-1:0] d_addr,
  input  logic [W-1:0] d_wdata,
  output logic [W-1:0] d_rdata,
  output logic         d_ack,
  // Memory port
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack,
  // Pipeline stalls and status
  output logic         stall_f,
  output logic         stall_m,
  output logic         bus_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam int unsigned StrW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {StIdle, StGrantD, StGrantI, StDone} state_e;

  state_e          state_q, state_d;
  logic [StrW-1:0] streak_q, streak_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [W-1:0]    mem_addr_q, mem_addr_d;
  logic [W-1:0]    mem_wdata_q, mem_wdata_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [W-1:0]    if_rdata_q, if_rdata_d;
  logic [W-1:0]    d_rdata_q, d_rdata_d;
  logic            bus_err_q, bus_err_d;

  // Next-state: arbitration in idle, watchdog and completion capture in grant.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = '0;
    d_rdata_d   = '0;
    bus_err_d   = bus_err_q;
    unique case (state_q)
      StIdle: begin
        if (d_req && (!if_req || (streak_q < StrW'(MAX_D_STREAK)))) begin
          state_d     = StGrantD;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // Only counts while a fetch waits; the guard above keeps it <= MAX_D_STREAK.
          streak_d    = if_req ? streak_q + 1'b1 : '0;
        end else if (if_req) begin
          state_d     = StGrantI;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end else begin
          streak_d    = '0;
        end
      end
      StGrantD, StGrantI: begin
        if (mem_ack || (tmo_q == TmoW'(TIMEOUT - 1))) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          tmo_d     = '0;
          if (state_q == StGrantD) begin
            d_ack_d   = 1'b1;
            d_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end
          // An ack in the final watchdog cycle still counts as a good completion.
          if (!mem_ack) begin
            bus_err_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDone: begin
        // Requester updates its request this cycle, so idle never re-grants it.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_err   = bus_err_q;

  assign stall_f = if_req & ~if_ack_q;
  assign stall_m = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written timeout and
// reset sequences, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned MaxStreak = 4;
  localparam logic [31:0] IfAddr    = 32'h0000_0100;
  localparam logic [31:0] DAddr     = 32'h0000_0040;
  localparam logic [31:0] StoreData = 32'hDEAD_BEEF;
  localparam logic [31:0] MemKey    = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_f;
  logic        stall_m;
  logic        bus_err;

  int   ack_delay = 0;   // memory answers this many cycles after mem_req rises; <0 = never
  int   wait_cnt = 0;
  logic force_ack = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  mem_port_arbiter #(
    .W            (32),
    .TIMEOUT      (16),
    .MAX_D_STREAK (MaxStreak)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_f   (stall_f),
    .stall_m   (stall_m),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ MemKey;
  endfunction

  // Memory model: word is a fixed function of address, ack after a programmable delay.
  assign mem_rdata = mem_word(mem_addr);
  assign mem_ack   = force_ack | (mem_req && (ack_delay >= 0) && (wait_cnt == ack_delay));

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Packed snapshot: {flags, granted addr, store data, acked read data}.
  function automatic logic [127:0] observe();
    logic [5:0] f;
    f = {mem_req, mem_req & mem_we, if_ack, d_ack, stall_f, stall_m};
    return {26'd0, f, (mem_req ? mem_addr : 32'h0), ((mem_req & mem_we) ? mem_wdata : 32'h0),
            (if_ack ? if_rdata : (d_ack ? d_rdata : 32'h0))};
  endfunction

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic [5:0]  flags;   // mem_req, mem_we, if_ack, d_ack, stall_f, stall_m
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic i, input logic d, input logic we, input logic [5:0] f,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    vec_t v;
    v.ireq = i; v.dreq = d; v.dwe = we; v.flags = f; v.addr = a; v.wdata = wd; v.rdata = rd;
    tbl.push_back(v);
  endtask

  // Random-phase model state
  int          run;
  bit          pi, pd, pdwe, prev_mreq, ack_due, ack_is_d, cur_d, saw_i, saw_d, exp_i, exp_d;
  logic [31:0] pia, pda, pdw, ack_val, cur_val;
  logic [64:0] exp_txn;
  int          gcnt;
  bit          seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1);
  end

  initial begin
    // Table: load, fetch starvation limit, simultaneous requests, store.
    add(0, 1, 0, 6'b000001, 0, 0, 0);
    add(0, 1, 0, 6'b100001, DAddr, 0, 0);
    add(0, 1, 0, 6'b000100, 0, 0, mem_word(DAddr));
    for (int k = 0; k < MaxStreak; k++) begin
      add(1, 1, 0, 6'b000011, 0, 0, 0);
      add(1, 1, 0, 6'b100011, DAddr, 0, 0);
      add(1, 1, 0, 6'b000110, 0, 0, mem_word(DAddr));
    end
    add(1, 1, 0, 6'b000011, 0, 0, 0);
    add(1, 1, 0, 6'b100011, IfAddr, 0, 0);
    add(1, 1, 0, 6'b001001, 0, 0, mem_word(IfAddr));
    add(0, 1, 0, 6'b000001, 0, 0, 0);
    add(0, 1, 0, 6'b100001, DAddr, 0, 0);
    add(0, 1, 0, 6'b000100, 0, 0, mem_word(DAddr));
    add(0, 0, 0, 6'b000000, 0, 0, 0);
    add(1, 1, 0, 6'b000011, 0, 0, 0);
    add(1, 1, 0, 6'b100011, DAddr, 0, 0);
    add(1, 1, 0, 6'b000110, 0, 0, mem_word(DAddr));
    add(1, 0, 0, 6'b000010, 0, 0, 0);
    add(1, 0, 0, 6'b100010, IfAddr, 0, 0);
    add(1, 0, 0, 6'b001000, 0, 0, mem_word(IfAddr));
    add(0, 0, 0, 6'b000000, 0, 0, 0);
    add(0, 1, 1, 6'b000001, 0, 0, 0);
    add(0, 1, 1, 6'b110001, DAddr, StoreData, 0);
    add(0, 1, 1, 6'b000100, 0, 0, 0);
    add(0, 0, 0, 6'b000000, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", observe(), 128'h0);
    check("reset_rdata", {if_rdata, d_rdata, mem_addr, mem_wdata}, 128'h0);
    check("reset_bus_err", bus_err, 0);

    if_addr = IfAddr; d_addr = DAddr; d_wdata = StoreData; ack_delay = 0;
    foreach (tbl[k]) begin
      @(posedge clk);
      #1;
      if_req = tbl[k].ireq; d_req = tbl[k].dreq; d_we = tbl[k].dwe;
      @(negedge clk);
      check($sformatf("vec%0d", k), observe(),
            {26'd0, tbl[k].flags, tbl[k].addr, tbl[k].wdata, tbl[k].rdata});
    end

    // Timeout: memory never answers a load
    @(posedge clk);
    #1 d_req = 1'b1; d_we = 1'b0; ack_delay = -1;
    gcnt = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (d_ack) seen = 1;
      else if (mem_req) gcnt++;
    end
    check("tmo_ack_seen", seen, 1);
    check("tmo_grant_cycles", gcnt, 16);
    check("tmo_ack_state", {mem_req, d_rdata, bus_err, if_ack}, {1'b0, 32'h0, 1'b1, 1'b0});

    // A good fetch afterwards leaves bus_err set
    @(posedge clk);
    #1 d_req = 1'b0; if_req = 1'b1; ack_delay = 0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (if_ack) seen = 1;
    end
    check("good_after_tmo", {seen, if_rdata, bus_err}, {1'b1, mem_word(IfAddr), 1'b1});

    // Reset in the middle of a grant, then a late memory ack
    @(posedge clk);
    #1 if_req = 1'b0; d_req = 1'b1; ack_delay = -1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    check("rst_grant_started", seen, 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1; d_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    check("rst_mid_grant", {observe(), bus_err}, {128'h0, 1'b0});
    @(posedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    check("rst_late_ack", observe(), 128'h0);
    ack_delay = 0;

    // Randomized traffic against a transaction-level model
    run = 0; pi = 0; pd = 0; pdwe = 0; prev_mreq = 0; ack_due = 0; ack_is_d = 0;
    cur_d = 0; saw_i = 0; saw_d = 0; pia = '0; pda = '0; pdw = '0; cur_val = '0; ack_val = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (!if_req || saw_i) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
      end
      if (!d_req || saw_d) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_we = $urandom_range(0, 1);
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      if (!mem_req) ack_delay = $urandom_range(0, 3);
      @(negedge clk);
      exp_i = ack_due && !ack_is_d;
      exp_d = ack_due && ack_is_d;
      check("rnd_ack", {if_ack, d_ack}, {exp_i, exp_d});
      if (ack_due) check("rnd_rdata", ack_is_d ? d_rdata : if_rdata, ack_val);
      check("rnd_stall", {stall_f, stall_m}, {if_req & !exp_i, d_req & !exp_d});
      if (mem_req && !prev_mreq) begin
        if (pd && (!pi || run < MaxStreak)) begin
          cur_d = 1; run = pi ? run + 1 : 0;
          cur_val = pdwe ? 32'h0 : mem_word(pda);
          exp_txn = {pdwe, pda, (pdwe ? pdw : 32'h0)};
          check("rnd_grant_d", {mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)}, exp_txn);
        end else if (pi) begin
          cur_d = 0; run = 0;
          cur_val = mem_word(pia);
          exp_txn = {1'b0, pia, 32'h0};
          check("rnd_grant_i", {mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)}, exp_txn);
        end else begin
          nvec++; nerr++;
          $display("FAIL rnd_grant_noreq: got mem_req=1 addr %0h, expected no grant", mem_addr);
        end
      end
      ack_due = mem_req && mem_ack;
      if (ack_due) begin
        ack_is_d = cur_d;
        ack_val = cur_val;
      end
      saw_i = if_ack; saw_d = d_ack;
      prev_mreq = mem_req;
      pi = if_req; pd = d_req; pdwe = d_we; pia = if_addr; pda = d_addr; pdw = d_wdata;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
